irq_pending_latch: RTL
======================

// Module: irq_pending_latch
// PURPOSE
//   Front end of the 8-line interrupt path. Synchronises raw request lines,
//   latches each request as a pending bit, and drives the masked pending
//   vector into the 8-to-3 priority encoder. Runs an assert/acknowledge/EOI
//   handshake with the CPU side, using the encoder's 3-bit index as ack_id.
// PARAMETERS
//   N_LINES      8   request lines; fixed at 8 to match the 8-to-3 encoder
//   SYNC_STAGES  2   flops per line in the input synchroniser (legal: 2..3)
// PORTS
//   clk         in   1  single clock; all state updates on the rising edge
//   rst         in   1  synchronous, active-high reset
//   irq_in      in   8  raw request lines, asynchronous to clk
//   irq_mask    in   8  1 = line masked (hidden from pend, still latched)
//   pend        out  8  pending & ~irq_mask; feeds encoder input D
//   irq_valid   out  1  high while an unmasked request is offered (ASSERT)
//   ack         in   1  CPU takes the request; valid only with irq_valid
//   ack_id      in   3  line being acknowledged (the encoder's Y output)
//   eoi         in   1  end of interrupt; ends SERVICE
//   in_service  out  8  one-hot line currently being serviced
//   spurious    out  1  1-cycle pulse: ack whose ack_id bit is not in pend
// BEHAVIOUR
//   Reset (rst=1 at an edge): sync flops, edge history, pending, in_service,
//     spurious = 0; state = IDLE; pend=0, irq_valid=0 next cycle.
//   A reset mid-SERVICE or mid-ASSERT drops every latched request. No recovery.
//   Synchroniser: SYNC_STAGES flops per line; s = last stage; prev = s delayed 1.
//   Edge detect: rise = s & ~prev. pending[i] is set on rise[i].
//   Latency: irq_in[i] high before edge k -> pending[i]/pend[i] high after
//     edge k+SYNC_STAGES (k+2 by default). A pulse must be held for at least
//     2 clk periods to be guaranteed seen.
//   pending[i] clears only on an accepted ack with ack_id==i.
//   Set and clear of the same bit in the same cycle: set wins (new edge kept).
//   The mask only gates pend. Unmasking a latched bit shows it on the next cycle.
//   FSM (registered state):
//     IDLE    -> ASSERT when |pend.
//     ASSERT  irq_valid=1. On ack with pend[ack_id]=1: clear pending[ack_id],
//             set in_service=1<<ack_id, go SERVICE.
//             On ack with pend[ack_id]=0: pulse spurious, stay in ASSERT.
//             If pend becomes 0 (masked) with no ack: back to IDLE.
//     SERVICE irq_valid=0; pending keeps accumulating. On eoi: in_service=0,
//             go IDLE. Re-evaluation happens the following cycle.
//   ack outside ASSERT and eoi outside SERVICE are ignored (no spurious pulse).
//   No nesting: one line in service at most; priority comes from the encoder.
// CONFIGURATION
//   LEVEL_MODE_EN defined: edge detect bypassed; pending[i] = s[i] every cycle
//     while not in service, so a line held high re-pends after EOI. An ack
//     clear has no effect while s[i] is still high; the latency is
//     SYNC_STAGES edges.
//   LEVEL_MODE_EN undefined (default): edge-triggered latching as above.
// TESTING
//   1 rst=1 for 2 cycles with irq_in=8'hFF -> pend=0, irq_valid=0,
//     in_service=0, spurious=0.
//   2 irq_in=8'h24 rising before edge k, mask=0 -> pend=8'h24 after edge k+2;
//     irq_valid=1 after k+3. ack, ack_id=5 -> pend=8'h04, in_service=8'h20.
//     eoi -> IDLE, then irq_valid=1 for line 2.
//   3 mask=8'h80, irq_in[7] rises -> pend=0, irq_valid=0. Clear the mask ->
//     pend=8'h80 the next cycle, irq_valid=1 one cycle later.
//   4 In ASSERT with pend=8'h01, ack with ack_id=3 -> spurious high for
//     exactly 1 cycle, pend stays 8'h01, state stays ASSERT.
//   5 During SERVICE of line 5, irq_in[5] pulses again -> pending[5] re-set,
//     irq_valid=0 until eoi; after eoi, irq_valid=1 with pend[5]=1.
//   6 rst asserted in SERVICE with pend=8'h11 -> all outputs 0 the next
//     cycle; eoi afterwards has no effect.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronises 8 raw request lines, latches them as pending bits and runs
// the assert/ack/EOI handshake. Define LEVEL_MODE_EN for level-sensitive (non-latching) pending.
module irq_pending_latch #(
    parameter int N_LINES     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_LINES-1:0]         irq_in,
    input  logic [N_LINES-1:0]         irq_mask,
    output logic [N_LINES-1:0]         pend,
    output logic                       irq_valid,
    input  logic                       ack,
    input  logic [$clog2(N_LINES)-1:0] ack_id,
    input  logic                       eoi,
    output logic [N_LINES-1:0]         in_service,
    output logic                       spurious
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [N_LINES-1:0] sync_q [SYNC_STAGES];
    logic [N_LINES-1:0] s;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic [N_LINES-1:0] in_service_q;
    logic [N_LINES-1:0] clr_vec;
    state_t             state_q;
    logic               irq_valid_q;
    logic               spurious_q;
    logic               ack_hit;
    logic               ack_miss;

    assign s        = sync_q[SYNC_STAGES-1];
    assign ack_hit  = (state_q == ASSERT) && ack && pend_q[ack_id];
    assign ack_miss = (state_q == ASSERT) && ack && !pend_q[ack_id];

    always_comb begin
        clr_vec = '0;
        if (ack_hit) clr_vec[ack_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef LEVEL_MODE_EN
    // Pending mirrors the synchronised level; the line being serviced is held off until EOI.
    always_comb begin
        pending_d = s & ~in_service_q;
    end
`else
    logic [N_LINES-1:0] prev_q;
    logic [N_LINES-1:0] rise;

    assign rise = s & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= '0;
        else     prev_q <= s;
    end

    // A new edge in the same cycle as its ack clear keeps the bit pending.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | rise;
    end
`endif

    assign pend_d = pending_d & ~irq_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            pend_q    <= '0;
        end else begin
            pending_q <= pending_d;
            pend_q    <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_valid_q  <= 1'b0;
            in_service_q <= '0;
            spurious_q   <= 1'b0;
        end else begin
            spurious_q <= ack_miss;
            case (state_q)
                IDLE: begin
                    if (|pend_q) begin
                        state_q     <= ASSERT;
                        irq_valid_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (ack_hit) begin
                        state_q      <= SERVICE;
                        irq_valid_q  <= 1'b0;
                        in_service_q <= clr_vec;
                    end else if (!(|pend_q)) begin
                        state_q     <= IDLE;
                        irq_valid_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_q      <= IDLE;
                        in_service_q <= '0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    irq_valid_q  <= 1'b0;
                    in_service_q <= '0;
                end
            endcase
        end
    end

    assign pend       = pend_q;
    assign irq_valid  = irq_valid_q;
    assign in_service = in_service_q;
    assign spurious   = spurious_q;

endmodule
